// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART paint-command frame controller.
// Frames are SYNC, OP, X, Y, COLOR, CHK, and each completed frame is answered with ACK or NAK.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    HUNT,
    GET_OP,
    GET_X,
    GET_Y,
    GET_COL,
    GET_CHK,
    ISSUE,
    SEND_RESP,
    TX_GUARD
  } state_t;

  localparam logic [7:0] OP_PLOT      = 8'h01;
  localparam logic [7:0] OP_CLEAR     = 8'h02;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_DEFAULT  = 8'h06;
  localparam logic [7:0] NAK_DEFAULT  = 8'h15;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap counter: clears on demand, counts while enabled, and flags the last allowed cycle.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  assign expire = enable && (count == LAST);

  // Holds at LAST so a late reaction by the FSM can never wrap the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame-level controller between the byte UART and the drawing engine.
// It assembles 6-byte frames, issues valid commands, and answers every frame with ACK or NAK.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter logic [7:0]  ACK_BYTE       = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  input  logic        rx_error,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_x,
  output logic [7:0]  cmd_y,
  output logic [7:0]  cmd_color,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  state_t     state;
  logic [7:0] op_q, x_q, y_q, col_q, chk_q, resp_q;
  logic       in_get, byte_pend, err_pend, expire;

  // While rx_ack is high the UART has not yet dropped rx_avail/rx_error, so that cycle is skipped.
  assign byte_pend = rx_avail && !rx_ack;
  assign err_pend  = rx_error && !rx_ack;
  assign in_get    = (state == GET_OP) || (state == GET_X) || (state == GET_Y) ||
                     (state == GET_COL) || (state == GET_CHK);

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (byte_pend || !in_get),
    .enable(in_get),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HUNT;
      rx_ack    <= 1'b0;
      tx_data   <= 8'h00;
      tx_wr     <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op    <= 8'h00;
      cmd_x     <= 8'h00;
      cmd_y     <= 8'h00;
      cmd_color <= 8'h00;
      frame_cnt <= 16'h0000;
      err_cnt   <= 8'h00;
      op_q      <= 8'h00;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      col_q     <= 8'h00;
      chk_q     <= 8'h00;
      resp_q    <= 8'h00;
    end else begin
      rx_ack <= 1'b0;
      tx_wr  <= 1'b0;
      case (state)
        HUNT: begin
          if (err_pend) begin
            rx_ack <= 1'b1;
          end else if (byte_pend) begin
            rx_ack <= 1'b1;
            if (rx_data == SYNC_BYTE) begin
              chk_q <= 8'h00;
              state <= GET_OP;
            end
          end
        end
        GET_OP, GET_X, GET_Y, GET_COL, GET_CHK: begin
          // A byte landing on the expiry cycle wins over the timeout.
          if (err_pend) begin
            rx_ack  <= 1'b1;
            err_cnt <= sat_inc8(err_cnt);
            resp_q  <= NAK_BYTE;
            state   <= SEND_RESP;
          end else if (byte_pend) begin
            rx_ack <= 1'b1;
            chk_q  <= chk_q ^ rx_data;
            case (state)
              GET_OP:  begin op_q  <= rx_data; state <= GET_X;   end
              GET_X:   begin x_q   <= rx_data; state <= GET_Y;   end
              GET_Y:   begin y_q   <= rx_data; state <= GET_COL; end
              GET_COL: begin col_q <= rx_data; state <= GET_CHK; end
              default: begin
                if ((rx_data == chk_q) && ((op_q == OP_PLOT) || (op_q == OP_CLEAR))) begin
                  cmd_valid <= 1'b1;
                  cmd_op    <= op_q;
                  cmd_x     <= x_q;
                  cmd_y     <= y_q;
                  cmd_color <= col_q;
                  state     <= ISSUE;
                end else begin
                  err_cnt <= sat_inc8(err_cnt);
                  resp_q  <= NAK_BYTE;
                  state   <= SEND_RESP;
                end
              end
            endcase
          end else if (expire) begin
            err_cnt <= sat_inc8(err_cnt);
            state   <= HUNT;
          end
        end
        ISSUE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            resp_q    <= ACK_BYTE;
            state     <= SEND_RESP;
          end
        end
        SEND_RESP: begin
          if (!tx_busy) begin
            tx_data <= resp_q;
            tx_wr   <= 1'b1;
            state   <= TX_GUARD;
          end
        end
        // Gives the UART one cycle to raise tx_busy before a new frame can be answered.
        TX_GUARD: state <= HUNT;
        default:  state <= HUNT;
      endcase
    end
  end

endmodule
